// File: rtl/puf_crp_collector_if.sv
// CRP output stream: {challenge, response} with a valid/ready handshake.
interface puf_crp_collector_if #(
  parameter int W = 65
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/puf_crp_collector.sv
// Snapshots a fully refreshed challenge, runs one PUF evaluation on it and
// delivers the challenge/response pair downstream.
module puf_crp_collector #(
  parameter int N_CB    = 64,
  parameter int N_RNG   = 4,
  parameter int N_RESP  = 1,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_CB-1:0]      C_in,
  output logic [N_CB-1:0]      puf_challenge,
  output logic                 puf_start,
  input  logic                 puf_done,
  input  logic [N_RESP-1:0]    puf_resp,
  puf_crp_collector_if.master  crp,
  output logic [15:0]          pair_cnt,
  output logic [7:0]           timeout_cnt
);

  localparam int REFRESH = N_CB / N_RNG;
  localparam int FW      = $clog2(REFRESH + 1);
  localparam int SW      = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DW      = N_CB + N_RESP;

  localparam logic [FW-1:0] FC_RELOAD = FW'(REFRESH);
  localparam logic [SW-1:0] S_LAST    = SW'(SETTLE - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [FW-1:0]   fc_r, fc_s;
  logic [SW-1:0]   scnt_r, scnt_s;
  logic [TW-1:0]   tcnt_r, tcnt_s;
  logic [N_CB-1:0] chal_r, chal_s;
  logic            start_r, start_s;
  logic            valid_r, valid_s;
  logic [DW-1:0]   data_r, data_s;
  logic [15:0]     pair_r, pair_s;
  logic [7:0]      tout_r, tout_s;
  logic            fresh_s;

  // fc counts down the shifts still needed before every challenge bit is new
  assign fresh_s = (fc_r == FW'(0));

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    fc_s    = fresh_s ? FW'(0) : (fc_r - FW'(1));
    scnt_s  = scnt_r;
    tcnt_s  = tcnt_r;
    chal_s  = chal_r;
    start_s = 1'b0;
    valid_s = valid_r;
    data_s  = data_r;
    pair_s  = pair_r;
    tout_s  = tout_r;
    case (state_r)
      ST_IDLE: begin
        if (en && fresh_s) begin
          chal_s  = C_in;
          fc_s    = FC_RELOAD;
          scnt_s  = SW'(0);
          state_s = ST_APPLY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (scnt_r == S_LAST) begin
          start_s = 1'b1;
          tcnt_s  = TW'(0);
          state_s = ST_WAIT;
        end else begin
          scnt_s  = scnt_r + SW'(1);
        end
      end
      ST_WAIT: begin
        // A response arriving on the expiry cycle still counts
        if (puf_done) begin
          data_s  = {chal_r, puf_resp};
          valid_s = 1'b1;
          state_s = ST_OUT;
        end else if (tcnt_r == T_LAST) begin
          if (tout_r != 8'hFF) begin
            tout_s = tout_r + 8'd1;
          end else begin
            tout_s = tout_r;
          end
          state_s = ST_IDLE;
        end else begin
          tcnt_s  = tcnt_r + TW'(1);
        end
      end
      ST_OUT: begin
        if (crp.out_ready) begin
          valid_s = 1'b0;
          pair_s  = pair_r + 16'd1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      fc_r    <= FC_RELOAD;
      scnt_r  <= SW'(0);
      tcnt_r  <= TW'(0);
      chal_r  <= {N_CB{1'b0}};
      start_r <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= {DW{1'b0}};
      pair_r  <= 16'd0;
      tout_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      fc_r    <= fc_s;
      scnt_r  <= scnt_s;
      tcnt_r  <= tcnt_s;
      chal_r  <= chal_s;
      start_r <= start_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      pair_r  <= pair_s;
      tout_r  <= tout_s;
    end
  end

  assign puf_challenge = chal_r;
  assign puf_start     = start_r;
  assign crp.out_valid = valid_r;
  assign crp.out_data  = data_r;
  assign pair_cnt      = pair_r;
  assign timeout_cnt   = tout_r;

endmodule

// File: tb/tb_puf_crp_collector.sv
// Directed bench for puf_crp_collector: freshness, CRP delivery, backpressure,
// timeout and races, reset and enable handling, timeout saturation.
module tb_puf_crp_collector;

  logic        clk = 1'b0;
  logic        rst, en, en2;
  logic [63:0] C_in;
  logic [63:0] chal1, chal2;
  logic        start1, start2;
  logic        puf_done, puf_done2;
  logic [0:0]  puf_resp, puf_resp2;
  logic [15:0] pair1, pair2;
  logic [7:0]  tout1, tout2;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int cyc = 0;
  logic [63:0] c_at0, c_at1, c_at2, cap;

  always #5 clk = ~clk;

  puf_crp_collector_if #(.W(65)) crp1 ();
  puf_crp_collector_if #(.W(65)) crp2 ();

  puf_crp_collector #(.N_CB(64), .N_RNG(4), .N_RESP(1), .SETTLE(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .en(en), .C_in(C_in),
    .puf_challenge(chal1), .puf_start(start1),
    .puf_done(puf_done), .puf_resp(puf_resp),
    .crp(crp1.master), .pair_cnt(pair1), .timeout_cnt(tout1)
  );

  // Short-timeout instance used to drive the timeout counter into saturation
  puf_crp_collector #(.N_CB(64), .N_RNG(4), .N_RESP(1), .SETTLE(2), .TIMEOUT(1)) dut_t (
    .clk(clk), .rst(rst), .en(en2), .C_in(C_in),
    .puf_challenge(chal2), .puf_start(start2),
    .puf_done(puf_done2), .puf_resp(puf_resp2),
    .crp(crp2.master), .pair_cnt(pair2), .timeout_cnt(tout2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; C_in mimics challenge_gen shifting in 4 TRNG bits per cycle
  task automatic tick();
    c_at2 = c_at1;
    c_at1 = c_at0;
    c_at0 = C_in;
    @(posedge clk);
    #1;
    if (rst) C_in = 64'd0;
    else     C_in = {C_in[59:0], 4'(cyc) ^ 4'hA};
    cyc++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    puf_done = 1'b0; puf_resp = 1'b0; puf_done2 = 1'b0; puf_resp2 = 1'b0;
    crp1.out_ready = 1'b0; crp2.out_ready = 1'b1;
    C_in = 64'd0; c_at0 = 64'd0; c_at1 = 64'd0; c_at2 = 64'd0; cap = 64'd0;
    repeat (3) tick();
    check("rst_chal", 128'(chal1), 128'(0));
    check("rst_start", 128'(start1), 128'(0));
    check("rst_valid", 128'(crp1.out_valid), 128'(0));
    check("rst_data", 128'(crp1.out_data), 128'(0));
    check("rst_pair", 128'(pair1), 128'(0));
    check("rst_tout", 128'(tout1), 128'(0));

    // Freshness: no capture on post-reset edges 0..15, capture on edge 16
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("early_cap", 128'(chal1), 128'(0));
      check("early_start", 128'(start1), 128'(0));
    end
    tick();
    check("first_cap", 128'(chal1), 128'(c_at0));
    cap = c_at0;
    check("cap_start0", 128'(start1), 128'(0));
    tick();
    check("settle_start0", 128'(start1), 128'(0));
    tick();
    check("start_hi", 128'(start1), 128'(1));

    // Normal CRP: done five cycles after puf_start, ready held high
    crp1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wait_start0", 128'(start1), 128'(0));
      check("wait_valid0", 128'(crp1.out_valid), 128'(0));
    end
    puf_done = 1'b1; puf_resp = 1'b1;
    tick();
    check("crp_valid", 128'(crp1.out_valid), 128'(1));
    check("crp_data", 128'(crp1.out_data), 128'({cap, 1'b1}));
    puf_done = 1'b0;
    tick();
    check("crp_valid_drop", 128'(crp1.out_valid), 128'(0));
    check("crp_pair1", 128'(pair1), 128'(1));

    // Next capture 17 edges after the previous one; then backpressure
    crp1.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("hold_chal", 128'(chal1), 128'(cap));
    end
    tick();
    check("second_cap", 128'(chal1), 128'(c_at0));
    cap = c_at0;
    tick();
    tick();
    check("start2_hi", 128'(start1), 128'(1));
    repeat (4) tick();
    puf_done = 1'b1; puf_resp = 1'b0;
    tick();
    check("bp_valid", 128'(crp1.out_valid), 128'(1));
    check("bp_data", 128'(crp1.out_data), 128'({cap, 1'b0}));
    puf_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_valid", 128'(crp1.out_valid), 128'(1));
      check("bp_hold_data", 128'(crp1.out_data), 128'({cap, 1'b0}));
      check("bp_no_cap", 128'(chal1), 128'(cap));
      check("bp_pair", 128'(pair1), 128'(1));
    end
    crp1.out_ready = 1'b1;
    tick();
    check("bp_release", 128'(crp1.out_valid), 128'(0));
    check("bp_pair2", 128'(pair1), 128'(2));

    // Timeout: no puf_done, IDLE 255 edges after puf_start
    tick();
    check("to_cap", 128'(chal1), 128'(c_at0));
    cap = c_at0;
    tick();
    tick();
    check("to_start", 128'(start1), 128'(1));
    for (int i = 0; i < 254; i++) begin
      tick();
      check("to_no_valid", 128'(crp1.out_valid), 128'(0));
      check("to_cnt0", 128'(tout1), 128'(0));
    end
    tick();
    check("to_cnt1", 128'(tout1), 128'(1));
    check("to_valid0", 128'(crp1.out_valid), 128'(0));
    tick();
    check("to_recap", 128'(chal1), 128'(c_at0));
    cap = c_at0;

    // Race: puf_done on the expiry edge wins
    tick();
    tick();
    check("race_start", 128'(start1), 128'(1));
    for (int i = 0; i < 254; i++) begin
      tick();
      check("race_no_valid", 128'(crp1.out_valid), 128'(0));
    end
    puf_done = 1'b1; puf_resp = 1'b1;
    tick();
    check("race_valid", 128'(crp1.out_valid), 128'(1));
    check("race_data", 128'(crp1.out_data), 128'({cap, 1'b1}));
    check("race_tout", 128'(tout1), 128'(1));
    puf_done = 1'b0;
    tick();
    check("race_pair", 128'(pair1), 128'(3));
    check("race_valid0", 128'(crp1.out_valid), 128'(0));

    // puf_done during APPLY is ignored
    tick();
    check("apply_cap", 128'(chal1), 128'(c_at0));
    cap = c_at0;
    puf_done = 1'b1; puf_resp = 1'b1;
    tick();
    check("apply_done_ign1", 128'(crp1.out_valid), 128'(0));
    tick();
    check("apply_start", 128'(start1), 128'(1));
    check("apply_done_ign2", 128'(crp1.out_valid), 128'(0));
    puf_done = 1'b0;
    tick();
    check("apply_done_ign3", 128'(crp1.out_valid), 128'(0));

    // en dropped during OUT: CRP completes, then block stays idle
    crp1.out_ready = 1'b0;
    tick();
    puf_done = 1'b1; puf_resp = 1'b0;
    tick();
    check("en_valid", 128'(crp1.out_valid), 128'(1));
    check("en_data", 128'(crp1.out_data), 128'({cap, 1'b0}));
    puf_done = 1'b0; en = 1'b0;
    tick();
    tick();
    check("en_hold", 128'(crp1.out_valid), 128'(1));
    crp1.out_ready = 1'b1;
    tick();
    check("en_done", 128'(crp1.out_valid), 128'(0));
    check("en_pair", 128'(pair1), 128'(4));
    for (int i = 0; i < 40; i++) begin
      tick();
      check("en_idle_chal", 128'(chal1), 128'(cap));
      check("en_idle_start", 128'(start1), 128'(0));
    end

    // Reset during WAIT
    en = 1'b1;
    tick();
    check("re_cap", 128'(chal1), 128'(c_at0));
    tick();
    tick();
    check("re_start", 128'(start1), 128'(1));
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_chal", 128'(chal1), 128'(0));
    check("mid_rst_start", 128'(start1), 128'(0));
    check("mid_rst_valid", 128'(crp1.out_valid), 128'(0));
    check("mid_rst_data", 128'(crp1.out_data), 128'(0));
    check("mid_rst_pair", 128'(pair1), 128'(0));
    check("mid_rst_tout", 128'(tout1), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("post_rst_nocap", 128'(chal1), 128'(0));
    end
    tick();
    check("post_rst_cap", 128'(chal1), 128'(c_at0));
    en = 1'b0;

    // Timeout counter saturation on the TIMEOUT=1 instance
    en2 = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_first", 128'(tout2), 128'(1));
    for (int i = 0; i < 5100; i++) begin
      tick();
      check("sat_no_valid", 128'(crp2.out_valid), 128'(0));
    end
    check("sat_cnt", 128'(tout2), 128'(255));
    check("sat_pair", 128'(pair2), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/puf_crp_collector.md
# puf_crp_collector

Consumer side of the challenge generator. Takes the free-running shift-register challenge `C`, waits until every bit has been replaced by fresh TRNG output, snapshots it, applies it to the PUF core, captures the response, and hands the challenge/response pair (CRP) downstream over a valid/ready handshake. It sits between `challenge_gen` and the CRP readout/UART path.

## Interface
- `N_CB`, 64: challenge width. Must match `challenge_gen`.
- `N_RNG`, 4: TRNG bits shifted into the challenge per clock. Must divide `N_CB`.
- `N_RESP`, 1: PUF response width.
- `SETTLE`, 2: cycles the challenge is held stable before `puf_start`. Minimum 1.
- `TIMEOUT`, 255: maximum cycles to wait for `puf_done`. Minimum 1.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: when high, collection runs continuously.
- `C_in`, in, N_CB: challenge from `challenge_gen.C`.
- `puf_challenge`, out, N_CB: registered challenge driven to the PUF.
- `puf_start`, out, 1: single-cycle evaluation strobe.
- `puf_done`, in, 1: PUF response valid, sampled as a pulse or level.
- `puf_resp`, in, N_RESP: PUF response, valid while `puf_done` is high.
- `out_valid`, out, 1: CRP available.
- `out_ready`, in, 1: downstream accept.
- `out_data`, out, N_CB+N_RESP: `{challenge, response}`.
- `pair_cnt`, out, 16: count of accepted CRPs. Wraps.
- `timeout_cnt`, out, 8: count of PUF timeouts. Saturates at 255.

## Operation
- **Freshness counter `fc`**
  - Reset value is REFRESH = N_CB/N_RNG.
  - Decrements every cycle, saturating at 0, in every state.
  - Reloads to REFRESH in the cycle a challenge is captured.
  - `fresh` = (`fc` == 0).
- **FSM states:** IDLE, APPLY, WAIT, OUT.
- **IDLE**
  - If `en` && `fresh`: capture `C_in` into `puf_challenge`, reload `fc`, clear the settle counter, go to APPLY.
  - Otherwise stay in IDLE.
- **APPLY**
  - Count SETTLE cycles.
  - On the last one, assert `puf_start` for exactly 1 cycle, clear the timeout counter, go to WAIT.
  - `puf_done` is ignored in this state.
- **WAIT**
  - If `puf_done`: latch `out_data` = {`puf_challenge`, `puf_resp`}, set `out_valid`, go to OUT.
  - Else, if the timeout counter reaches TIMEOUT: increment `timeout_cnt` (saturating), produce no output, go to IDLE.
  - If `puf_done` and timeout occur in the same cycle, `puf_done` wins.
- **OUT**
  - Hold `out_valid` and `out_data` stable until `out_ready`.
  - On handshake (`out_valid` && `out_ready`): clear `out_valid`, increment `pair_cnt` (mod 2^16), go to IDLE.
- **`en` handling**
  - `en` is sampled only in IDLE.
  - Deasserting `en` mid-transaction does not abort; the current CRP completes and is delivered.
- `puf_challenge` changes only on capture. It is stable from APPLY through OUT.
- `rst` in any state aborts the transaction. No partial CRP is emitted.

## Timing
- **Reset values:**
  - `puf_challenge` = 0, `puf_start` = 0, `out_valid` = 0, `out_data` = 0.
  - `pair_cnt` = 0, `timeout_cnt` = 0.
  - FSM = IDLE, `fc` = REFRESH.
- **First capture after reset:** no earlier than cycle REFRESH after `rst` deassert (cycle 16 with defaults). This guarantees no reset-state bits of `C` remain in the challenge.
- **Capture to `puf_start`:** `puf_start` is high in the cycle SETTLE clocks after the capture edge.
- **`puf_done` to `out_valid`:** 1 cycle.
- **Handshake to next capture:**
  - Next capture occurs in the first IDLE cycle where `fresh` is true.
  - Back-to-back CRPs are therefore separated by at least max(REFRESH, SETTLE+3) cycles.
- **Timeout:** measured from the cycle after `puf_start`. TIMEOUT cycles without `puf_done` returns to IDLE on the next edge.
- **`out_ready` high while `out_valid` is low** has no effect.
- `out_ready` may be held high permanently. Each CRP is then accepted in its first OUT cycle.

## Test plan
- **Reset/freshness:**
  - Stimulus: `en`=1 from reset release, `C_in` driven by a model shifting 4 bits/cycle.
  - Required: first capture at cycle 16; `puf_challenge` equals the model's `C` at that edge; `puf_start` is high 2 cycles later.
- **Normal CRP:**
  - Stimulus: PUF model returns `puf_done` with `puf_resp`=1 five cycles after `puf_start`; `out_ready`=1.
  - Required: `out_data` = {captured C, 1'b1}; `out_valid` is high 1 cycle; `pair_cnt` = 1.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 20 cycles, then 1.
  - Required: `out_valid` and `out_data` are stable throughout; no new capture occurs; `pair_cnt` increments once.
- **Timeout:**
  - Stimulus: PUF model never asserts `puf_done`.
  - Required: return to IDLE 255 cycles after `puf_start`; `timeout_cnt` = 1; `out_valid` is never asserted.
  - Stimulus: repeat 300 times. Required: `timeout_cnt` saturates at 255.
- **Edge races:**
  - Stimulus: `puf_done` in the same cycle the timeout expires. Required: CRP delivered, `timeout_cnt` unchanged.
  - Stimulus: `puf_done` during APPLY. Required: ignored.
- **Reset mid-operation / `en` drop:**
  - Stimulus: `rst` during WAIT. Required: all outputs return to reset values next cycle; next capture is ≥16 cycles later.
  - Stimulus: `en`=0 during OUT. Required: the CRP still completes, then the block stays in IDLE.
